// File: rtl/coherence_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter_if
// Purpose : Bundles the request/response signals between two CPU cache
//           controllers, the unified-memory controller and the coherence bus
//           arbiter.
// Signals : per CPU n (0,1)
//             rm_n, wm_n, inv_n   request lines (read miss, write miss, inval)
//             bico_n[12:0]        block tag of the request
//             found_n             snoop hit reported by that CPU's cache
//             grant_n             CPU n owns the bus
//             cpu_search_n        snoop strobe towards CPU n
//             cpu_datasel_n[1:0]  data source: 00 own, 01 memory, 10 other CPU
//             inval_other_n       invalidate strobe towards CPU n
//           shared
//             u_rdy               unified-memory operation complete
//             boci[12:0]          latched tag of the winning request
//             u_sel               CPU currently routed to unified memory
// Modports: master = requester side (caches + memory), slave = arbiter.
// -----------------------------------------------------------------------------
interface coherence_bus_arbiter_if;
    logic        rm_0;
    logic        wm_0;
    logic        inv_0;
    logic [12:0] bico_0;
    logic        found_0;
    logic        rm_1;
    logic        wm_1;
    logic        inv_1;
    logic [12:0] bico_1;
    logic        found_1;
    logic        u_rdy;

    logic        grant_0;
    logic        cpu_search_0;
    logic [1:0]  cpu_datasel_0;
    logic        inval_other_0;
    logic        grant_1;
    logic        cpu_search_1;
    logic [1:0]  cpu_datasel_1;
    logic        inval_other_1;
    logic [12:0] boci;
    logic        u_sel;

    modport master (
        output rm_0, wm_0, inv_0, bico_0, found_0,
        output rm_1, wm_1, inv_1, bico_1, found_1,
        output u_rdy,
        input  grant_0, cpu_search_0, cpu_datasel_0, inval_other_0,
        input  grant_1, cpu_search_1, cpu_datasel_1, inval_other_1,
        input  boci, u_sel
    );

    modport slave (
        input  rm_0, wm_0, inv_0, bico_0, found_0,
        input  rm_1, wm_1, inv_1, bico_1, found_1,
        input  u_rdy,
        output grant_0, cpu_search_0, cpu_datasel_0, inval_other_0,
        output grant_1, cpu_search_1, cpu_datasel_1, inval_other_1,
        output boci, u_sel
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter
// Purpose : Arbitrates coherence transactions of two CPU caches. The winner is
//           granted the bus, the other cache is snooped; a remote hit is
//           served cache-to-cache (XFER), a miss goes to unified memory (MEM),
//           and an invalidate request only strobes the other cache (INVAL).
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    coherence_bus_arbiter_if.slave (requests in, grants/strobes
//                  /data selects/latched tag out)
// Config  : ARB_RR_EN defined   -> round-robin on simultaneous requests
//           ARB_RR_EN undefined -> fixed priority, CPU0 wins ties
// All outputs are decoded from registers only (state, winner, request kind).
// -----------------------------------------------------------------------------
module coherence_bus_arbiter (
    input  logic                     clk,
    input  logic                     rst_n,
    coherence_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        CHECK = 3'd2,
        XFER  = 3'd3,
        MEM   = 3'd4,
        INVAL = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        REQ_RM  = 2'd0,
        REQ_WM  = 2'd1,
        REQ_INV = 2'd2
    } req_t;

    state_t      state_q, state_d;
    req_t        kind_q, kind_d;
    logic        winner_q, winner_d;
    logic [12:0] boci_q, boci_d;

    logic [1:0]  req_any;
    logic [1:0]  req_inv;
    logic [1:0]  req_wm;
    logic [1:0]  found_v;
    logic        win_sel;

    assign req_any = {bus.rm_1 | bus.wm_1 | bus.inv_1, bus.rm_0 | bus.wm_0 | bus.inv_0};
    assign req_inv = {bus.inv_1, bus.inv_0};
    assign req_wm  = {bus.wm_1, bus.wm_0};
    assign found_v = {bus.found_1, bus.found_0};

    // ------------------------------------------------------------------
    // Winner selection (only meaningful when at least one CPU requests)
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    // ptr_q names the CPU preferred on a tie: the one not granted last.
    logic ptr_q, ptr_d;

    always_comb begin
        if (req_any == 2'b11) begin
            win_sel = ptr_q;
        end else begin
            win_sel = req_any[1];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            ptr_d = ~winner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // CPU0 wins whenever it requests.
    assign win_sel = ~req_any[0];
`endif

    // ------------------------------------------------------------------
    // State and transaction context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= REQ_RM;
            winner_q <= 1'b0;
            boci_q   <= 13'd0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            winner_q <= winner_d;
            boci_q   <= boci_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        winner_d = winner_q;
        boci_d   = boci_q;
        case (state_q)
            IDLE: begin
                if (|req_any) begin
                    winner_d = win_sel;
                    boci_d   = win_sel ? bus.bico_1 : bus.bico_0;
                    if (req_inv[win_sel]) begin
                        kind_d  = REQ_INV;
                        state_d = INVAL;
                    end else begin
                        kind_d  = req_wm[win_sel] ? REQ_WM : REQ_RM;
                        state_d = SNOOP;
                    end
                end
            end
            SNOOP: state_d = CHECK;
            // The non-winner's cache answered the snoop issued last cycle.
            CHECK: state_d = found_v[~winner_q] ? XFER : MEM;
            XFER:  state_d = DONE;
            MEM: begin
                if (bus.u_rdy) begin
                    state_d = DONE;
                end
            end
            INVAL: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode, one slice per CPU
    // ------------------------------------------------------------------
    logic       active;
    logic [1:0] grant_v;
    logic [1:0] search_v;
    logic [1:0] inval_v;
    logic [1:0] datasel_v [2];

    assign active = (state_q != IDLE) && (state_q != DONE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cpu
            localparam logic ID = (gi == 1);
            logic is_winner;
            assign is_winner     = (winner_q == ID);
            assign grant_v[gi]   = active && is_winner;
            assign search_v[gi]  = (state_q == SNOOP) && !is_winner;
            // Only the write-miss flavour of a cache-to-cache transfer
            // invalidates the supplier's copy.
            assign inval_v[gi]   = !is_winner &&
                                   ((state_q == INVAL) ||
                                    ((state_q == XFER) && (kind_q == REQ_WM)));
            assign datasel_v[gi] = !is_winner         ? 2'b00 :
                                   (state_q == XFER)  ? 2'b10 :
                                   (state_q == MEM)   ? 2'b01 : 2'b00;
        end
    endgenerate

    assign bus.grant_0       = grant_v[0];
    assign bus.grant_1       = grant_v[1];
    assign bus.cpu_search_0  = search_v[0];
    assign bus.cpu_search_1  = search_v[1];
    assign bus.inval_other_0 = inval_v[0];
    assign bus.inval_other_1 = inval_v[1];
    assign bus.cpu_datasel_0 = datasel_v[0];
    assign bus.cpu_datasel_1 = datasel_v[1];
    assign bus.boci          = boci_q;
    assign bus.u_sel         = (state_q == MEM) && winner_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
module tb_coherence_bus_arbiter;

    logic clk;
    logic rst_n;

    coherence_bus_arbiter_if bus ();

    coherence_bus_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending request per CPU, its type bits {inv,wm,rm},
    // its tag, and the CPU granted most recently.
    bit [1:0]    pend;
    bit [2:0]    ptype [2];
    logic [12:0] ptag  [2];
    bit          last_win;

    // {grant0,grant1,search0,search1,datasel0,datasel1,inval0,inval1,u_sel}
    function automatic logic [10:0] obs_vec();
        return {bus.grant_0, bus.grant_1, bus.cpu_search_0, bus.cpu_search_1,
                bus.cpu_datasel_0, bus.cpu_datasel_1,
                bus.inval_other_0, bus.inval_other_1, bus.u_sel};
    endfunction

    function automatic logic [10:0] mk(bit [1:0] g, bit [1:0] s, logic [1:0] d0,
                                       logic [1:0] d1, bit [1:0] iv, bit us);
        return {g[0], g[1], s[0], s[1], d0, d1, iv[0], iv[1], us};
    endfunction

    function automatic bit [1:0] onehot(bit cpu);
        return cpu ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_reqs();
        bus.inv_0  = pend[0] & ptype[0][2];
        bus.wm_0   = pend[0] & ptype[0][1];
        bus.rm_0   = pend[0] & ptype[0][0];
        bus.bico_0 = ptag[0];
        bus.inv_1  = pend[1] & ptype[1][2];
        bus.wm_1   = pend[1] & ptype[1][1];
        bus.rm_1   = pend[1] & ptype[1][0];
        bus.bico_1 = ptag[1];
    endtask

    task automatic do_reset();
        pend     = 2'b00;
        last_win = 1'b1;
        drive_reqs();
        bus.u_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one complete transaction from an IDLE cycle, checking every cycle
    // against what the rules predict for the current pending requests.
    task automatic test_transaction(input string nm, input bit fnd, input int mem_dly,
                                    input bit drop_early, input bit keep, output bit obs_win);
        bit         win, oth, is_inv, is_wm;
        bit [2:0]   ty;
        logic [1:0] dw;
        logic [10:0] exp_v, got;
        if (pend == 2'b11) begin
`ifdef ARB_RR_EN
            win = ~last_win;
`else
            win = 1'b0;
`endif
        end else begin
            win = pend[1];
        end
        oth    = ~win;
        ty     = ptype[win];
        is_inv = ty[2];
        is_wm  = !is_inv && ty[1];
        drive_reqs();
        // winner's own found is driven opposite to catch sampling the wrong CPU
        if (win) begin bus.found_0 = fnd; bus.found_1 = ~fnd; end
        else     begin bus.found_1 = fnd; bus.found_0 = ~fnd; end

        got = obs_vec(); n_checks++;
        if (got !== 11'd0) $display("FAIL %s idle: got %b want %b", nm, got, 11'd0);
        else n_pass++;

        @(negedge clk);                               // k+1
        obs_win = bus.grant_1;
        n_checks++;
        if (bus.boci !== ptag[win]) $display("FAIL %s boci: got %h want %h", nm, bus.boci, ptag[win]);
        else n_pass++;
        if (drop_early) begin
            pend[win] = 1'b0;
            drive_reqs();
        end
        if (is_inv) begin
            exp_v = mk(onehot(win), 2'b00, 2'b00, 2'b00, onehot(oth), 1'b0);
            got = obs_vec(); n_checks++;
            if (got !== exp_v) $display("FAIL %s inval: got %b want %b", nm, got, exp_v);
            else n_pass++;
            bus.u_rdy = 1'($urandom);
            @(negedge clk);
        end else begin
            exp_v = mk(onehot(win), onehot(oth), 2'b00, 2'b00, 2'b00, 1'b0);
            got = obs_vec(); n_checks++;
            if (got !== exp_v) $display("FAIL %s snoop: got %b want %b", nm, got, exp_v);
            else n_pass++;
            bus.u_rdy = 1'($urandom);
            @(negedge clk);                           // k+2 CHECK
            exp_v = mk(onehot(win), 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            got = obs_vec(); n_checks++;
            if (got !== exp_v) $display("FAIL %s check: got %b want %b", nm, got, exp_v);
            else n_pass++;
            bus.u_rdy = 1'($urandom);
            @(negedge clk);                           // k+3
            if (fnd) begin
                dw = 2'b10;
                exp_v = mk(onehot(win), 2'b00, win ? 2'b00 : dw, win ? dw : 2'b00,
                           is_wm ? onehot(oth) : 2'b00, 1'b0);
                got = obs_vec(); n_checks++;
                if (got !== exp_v) $display("FAIL %s xfer: got %b want %b", nm, got, exp_v);
                else n_pass++;
                @(negedge clk);
            end else begin
                dw = 2'b01;
                exp_v = mk(onehot(win), 2'b00, win ? 2'b00 : dw, win ? dw : 2'b00, 2'b00, win);
                for (int i = 0; i <= mem_dly; i++) begin
                    got = obs_vec(); n_checks++;
                    if (got !== exp_v) $display("FAIL %s mem[%0d]: got %b want %b", nm, i, got, exp_v);
                    else n_pass++;
                    bus.u_rdy = (i == mem_dly);
                    @(negedge clk);
                end
                bus.u_rdy = 1'b0;
            end
        end
        // DONE: everything low; requester drops its request here
        got = obs_vec(); n_checks++;
        if (got !== 11'd0) $display("FAIL %s done: got %b want %b", nm, got, 11'd0);
        else n_pass++;
        bus.u_rdy = 1'b0;
        if (!keep) pend[win] = 1'b0;
        drive_reqs();
        last_win = win;
        @(negedge clk);
        $display("txn %s: winner=%0d type=%b found=%0d mem_dly=%0d tag=%h", nm, win, ty, fnd, mem_dly, ptag[win]);
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst_n = 1'b0;
        #1;
        got = obs_vec(); n_checks++;
        if (got !== 11'd0) $display("FAIL reset_outputs: got %b want %b", got, 11'd0);
        else n_pass++;
        n_checks++;
        if (bus.boci !== 13'd0) $display("FAIL reset_boci: got %h want %h", bus.boci, 13'd0);
        else n_pass++;
        do_reset();
        $display("txn reset: done");
    endtask

    task automatic test_single_read();
        bit w;
        pend = 2'b01; ptype[0] = 3'b001; ptag[0] = 13'h0A5;
        test_transaction("single_read", 1'b0, 5, 1'b0, 1'b0, w);
    endtask

    task automatic test_remote_hit_wm();
        bit w;
        pend = 2'b10; ptype[1] = 3'b010; ptag[1] = 13'h1F3;
        test_transaction("remote_hit_wm", 1'b1, 0, 1'b0, 1'b0, w);
    endtask

    task automatic test_invalidate();
        bit w;
        pend = 2'b01; ptype[0] = 3'b110; ptag[0] = 13'h0777;
        test_transaction("invalidate", 1'b0, 0, 1'b0, 1'b0, w);
    endtask

    task automatic test_reset_in_mem();
        logic [10:0] got;
        pend = 2'b01; ptype[0] = 3'b001; ptag[0] = 13'h0123;
        drive_reqs();
        bus.found_1 = 1'b0;
        repeat (3) @(negedge clk);                    // now in MEM
        got = obs_vec(); n_checks++;
        if (got !== mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0))
            $display("FAIL rst_mem_pre: got %b want %b", got, mk(2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        got = obs_vec(); n_checks++;
        if (got !== 11'd0 || bus.boci !== 13'd0) $display("FAIL rst_mem_async: got %b/%h want 0/0", got, bus.boci);
        else n_pass++;
        pend = 2'b00; last_win = 1'b1;
        drive_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.u_rdy = 1'b1;
        @(negedge clk);
        bus.u_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = obs_vec(); n_checks++;
            if (got !== 11'd0) $display("FAIL rst_mem_after[%0d]: got %b want %b", i, got, 11'd0);
            else n_pass++;
            @(negedge clk);
        end
        $display("txn reset_in_mem: done");
    endtask

    task automatic test_tie();
        bit w;
        bit exp_order [4];
`ifdef ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        pend = 2'b11; ptype[0] = 3'b001; ptype[1] = 3'b001;
        ptag[0] = 13'h0010; ptag[1] = 13'h0020;
        for (int t = 0; t < 4; t++) begin
            test_transaction("tie", t[0], 1, 1'b0, 1'b1, w);
            n_checks++;
            if (w !== exp_order[t]) $display("FAIL tie_order[%0d]: got %0d want %0d", t, w, exp_order[t]);
            else n_pass++;
        end
        pend = 2'b00;
        drive_reqs();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit w;
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && ($urandom_range(0, 2) != 0)) begin
                    pend[c]  = 1'b1;
                    ptype[c] = 3'($urandom_range(1, 7));
                    ptag[c]  = 13'($urandom);
                end
            end
            if (pend == 2'b00) begin
                w = 1'($urandom);
                pend[w]  = 1'b1;
                ptype[w] = 3'($urandom_range(1, 7));
                ptag[w]  = 13'($urandom);
            end
            test_transaction("random", 1'($urandom), int'($urandom_range(0, 6)),
                             ($urandom_range(0, 3) == 0), 1'b0, w);
        end
    endtask

    initial begin
        pend = 2'b00;
        ptype[0] = 3'b000; ptype[1] = 3'b000;
        ptag[0] = 13'd0; ptag[1] = 13'd0;
        last_win = 1'b1;
        drive_reqs();
        bus.found_0 = 1'b0;
        bus.found_1 = 1'b0;
        bus.u_rdy   = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_remote_hit_wm();
        test_invalidate();
        test_reset_in_mem();
        test_tie();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
